rob_commit: RTL and testbench

- Reorder buffer and in-order commit unit at the consumer end of the execute-stage result interface.
- Allocates ROB pointers at dispatch and captures execute results and load data by ROB pointer.
- Retires the oldest completed entry each cycle and drives the commit-stage forwarding bus (fwd_*_COM, LS_fwd_*_COM) back to execute.
- Also produces store-commit requests and taken-branch/jump flush with redirect PC.

---
 rtl/rob_commit_pkg.sv | 28 ++
 rtl/rob_commit_ptr_ctrl.sv | 38 +++
 rtl/rob_commit.sv | 186 ++++++++++++++++++
 tb/tb_rob_commit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared types for the reorder buffer: per-entry state and the latched execute payload.
package rob_commit_pkg;

   localparam int unsigned ROBWIDTH_DEF = 6;
   localparam int unsigned XLEN         = 32;
   localparam int unsigned REGW         = 6;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_WAITLD = 2'd2,
      ST_DONE   = 2'd3
   } rob_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [REGW-1:0] wreg;
      logic            regdest;
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] sdata;
      logic            isload;
      logic            isstore;
      logic            taken;
      logic [XLEN-1:0] target;
   } rob_entry_t;

endpackage

// File: rtl/rob_commit_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the ROB; a flush collapses everything back to empty.
module rob_ptr_ctrl
   import rob_commit_pkg::*;
#(
   parameter int unsigned ROBWIDTH = ROBWIDTH_DEF
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                push,
   input  logic                pop,
   input  logic                flush,
   output logic [ROBWIDTH-1:0] head,
   output logic [ROBWIDTH-1:0] tail,
   output logic [ROBWIDTH:0]   count,
   output logic                full_c,
   output logic                empty_c
);

   localparam int unsigned CW    = ROBWIDTH + 1;
   localparam int unsigned DEPTH = 2 ** ROBWIDTH;

   // Pointers wrap naturally at depth; count carries one extra bit so full != empty.
   always_ff @(posedge CLK) begin
      if (!RESET || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + ROBWIDTH'(1);
         if (pop)  head <= head + ROBWIDTH'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign full_c  = (count == CW'(DEPTH));
   assign empty_c = (count == '0);

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-entry commit, commit-stage forwarding,
// store-commit requests and taken-branch flush.
module rob_commit
   import rob_commit_pkg::*;
#(
   parameter int unsigned ROBWIDTH = ROBWIDTH_DEF
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                FREEZE,
   input  logic                Dispatch_Valid_IN,
   output logic                Dispatch_Ready_OUT,
   output logic [ROBWIDTH-1:0] ROBPointer_Alloc_OUT,
   input  logic                Valid_Instruction_IN,
   input  logic [ROBWIDTH-1:0] ROBPointer_IN,
   input  logic [31:0]         PCA_IN,
   input  logic [5:0]          writeRegister1_IN,
   input  logic                RegDest_IN,
   input  logic [31:0]         aluresult_IN,
   input  logic [31:0]         address_IN,
   input  logic [31:0]         Dest_Value1_IN,
   input  logic                MemRead1_IN,
   input  logic                MemWrite1_IN,
   input  logic                Branch_flag_IN,
   input  logic [31:0]         target_PC_IN,
   input  logic                LoadData_Valid_IN,
   input  logic [ROBWIDTH-1:0] LoadData_ROB_IN,
   input  logic [31:0]         LoadData_IN,
   output logic [31:0]         fwd_data_1_COM,
   output logic [5:0]          fwd_reg_1_COM,
   output logic                fwd_data_1_COM_flag,
   output logic [31:0]         LS_fwd_data_COM,
   output logic [5:0]          LS_fwd_reg_COM,
   output logic                LS_fwd_data_COM_flag,
   output logic                Store_Commit_OUT,
   output logic [31:0]         Store_Address_OUT,
   output logic [31:0]         Store_Data_OUT,
   output logic                Flush_OUT,
   output logic [31:0]         Redirect_PC_OUT,
   output logic [ROBWIDTH:0]   Count_OUT,
   output logic                Empty_OUT
);

   localparam int unsigned DEPTH = 2 ** ROBWIDTH;

   rob_state_e          state_q [DEPTH];
   rob_state_e          state_d [DEPTH];
   rob_entry_t          ent_q   [DEPTH];

   logic [ROBWIDTH-1:0] head;
   logic [ROBWIDTH-1:0] tail;
   logic [ROBWIDTH:0]   count;
   logic                full_c;
   logic                empty_c;

   logic                ready_c;
   logic                push_c;
   logic                commit_c;
   logic                flush_c;
   logic                ex_fire_c;
   logic                ld_fire_c;
   rob_entry_t          head_ent_c;
   rob_entry_t          ex_ent_c;
   logic                unused_pc_c;

   rob_ptr_ctrl #(
      .ROBWIDTH (ROBWIDTH)
   ) u_ptr (
      .CLK     (CLK),
      .RESET   (RESET),
      .push    (push_c),
      .pop     (commit_c),
      .flush   (flush_c),
      .head    (head),
      .tail    (tail),
      .count   (count),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   // Handshake and event qualification; a flushing commit suppresses all other updates.
   assign head_ent_c = ent_q[head];
   assign ready_c    = !full_c && !FREEZE;
   assign commit_c   = !FREEZE && !empty_c && (state_q[head] == ST_DONE);
   assign flush_c    = commit_c && head_ent_c.taken;
   assign push_c     = Dispatch_Valid_IN && ready_c && !flush_c;
   assign ex_fire_c  = Valid_Instruction_IN && (state_q[ROBPointer_IN] == ST_PEND) && !flush_c;
   assign ld_fire_c  = LoadData_Valid_IN && (state_q[LoadData_ROB_IN] == ST_WAITLD) && !flush_c;

   // PC is kept with the entry for debug visibility only.
   assign unused_pc_c = ^head_ent_c.pc;

   always_comb begin
      ex_ent_c         = '0;
      ex_ent_c.pc      = PCA_IN;
      ex_ent_c.wreg    = writeRegister1_IN;
      ex_ent_c.regdest = RegDest_IN;
      ex_ent_c.result  = aluresult_IN;
      ex_ent_c.addr    = address_IN;
      ex_ent_c.sdata   = Dest_Value1_IN;
      ex_ent_c.isload  = MemRead1_IN;
      ex_ent_c.isstore = MemWrite1_IN;
      ex_ent_c.taken   = Branch_flag_IN;
      ex_ent_c.target  = target_PC_IN;
   end

   // Entry state next-state; the pre-edge state gates each path, so a load return
   // cannot hit an entry whose execute write lands in the same cycle.
   always_comb begin
      state_d = state_q;
      if (flush_c) begin
         state_d = '{default: ST_FREE};
      end else begin
         if (push_c)    state_d[tail]            = ST_PEND;
         if (ex_fire_c) state_d[ROBPointer_IN]   = MemRead1_IN ? ST_WAITLD : ST_DONE;
         if (ld_fire_c) state_d[LoadData_ROB_IN] = ST_DONE;
         if (commit_c)  state_d[head]            = ST_FREE;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= '{default: ST_FREE};
      end else begin
         state_q <= state_d;
      end
   end

   // Payload storage; validity is tracked solely by state_q, so no reset is needed.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         if (ex_fire_c) ent_q[ROBPointer_IN]          <= ex_ent_c;
         if (ld_fire_c) ent_q[LoadData_ROB_IN].result <= LoadData_IN;
      end
   end

   // Commit outputs: single-cycle flags, data/reg held until the next qualifying commit.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         fwd_data_1_COM       <= '0;
         fwd_reg_1_COM        <= '0;
         fwd_data_1_COM_flag  <= 1'b0;
         LS_fwd_data_COM      <= '0;
         LS_fwd_reg_COM       <= '0;
         LS_fwd_data_COM_flag <= 1'b0;
         Store_Commit_OUT     <= 1'b0;
         Store_Address_OUT    <= '0;
         Store_Data_OUT       <= '0;
         Flush_OUT            <= 1'b0;
         Redirect_PC_OUT      <= '0;
      end else begin
         fwd_data_1_COM_flag  <= 1'b0;
         LS_fwd_data_COM_flag <= 1'b0;
         Store_Commit_OUT     <= 1'b0;
         Flush_OUT            <= 1'b0;
         if (commit_c) begin
            if (!head_ent_c.isload && !head_ent_c.isstore && head_ent_c.regdest &&
                (head_ent_c.wreg != '0)) begin
               fwd_data_1_COM_flag <= 1'b1;
               fwd_data_1_COM      <= head_ent_c.result;
               fwd_reg_1_COM       <= head_ent_c.wreg;
            end
            if (head_ent_c.isload && (head_ent_c.wreg != '0)) begin
               LS_fwd_data_COM_flag <= 1'b1;
               LS_fwd_data_COM      <= head_ent_c.result;
               LS_fwd_reg_COM       <= head_ent_c.wreg;
            end
            if (head_ent_c.isstore) begin
               Store_Commit_OUT  <= 1'b1;
               Store_Address_OUT <= head_ent_c.addr;
               Store_Data_OUT    <= head_ent_c.sdata;
            end
            if (head_ent_c.taken) begin
               Flush_OUT       <= 1'b1;
               Redirect_PC_OUT <= head_ent_c.target;
            end
         end
      end
   end

   assign Dispatch_Ready_OUT   = ready_c;
   assign ROBPointer_Alloc_OUT = tail;
   assign Count_OUT            = count;
   assign Empty_OUT            = empty_c;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_rob_commit;

   localparam int RW    = 6;
   localparam int DEPTH = 64;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          FREEZE;
   logic          Dispatch_Valid_IN;
   logic          Dispatch_Ready_OUT;
   logic [RW-1:0] ROBPointer_Alloc_OUT;
   logic          Valid_Instruction_IN;
   logic [RW-1:0] ROBPointer_IN;
   logic [31:0]   PCA_IN;
   logic [5:0]    writeRegister1_IN;
   logic          RegDest_IN;
   logic [31:0]   aluresult_IN;
   logic [31:0]   address_IN;
   logic [31:0]   Dest_Value1_IN;
   logic          MemRead1_IN;
   logic          MemWrite1_IN;
   logic          Branch_flag_IN;
   logic [31:0]   target_PC_IN;
   logic          LoadData_Valid_IN;
   logic [RW-1:0] LoadData_ROB_IN;
   logic [31:0]   LoadData_IN;
   logic [31:0]   fwd_data_1_COM;
   logic [5:0]    fwd_reg_1_COM;
   logic          fwd_data_1_COM_flag;
   logic [31:0]   LS_fwd_data_COM;
   logic [5:0]    LS_fwd_reg_COM;
   logic          LS_fwd_data_COM_flag;
   logic          Store_Commit_OUT;
   logic [31:0]   Store_Address_OUT;
   logic [31:0]   Store_Data_OUT;
   logic          Flush_OUT;
   logic [31:0]   Redirect_PC_OUT;
   logic [RW:0]   Count_OUT;
   logic          Empty_OUT;

   rob_commit #(.ROBWIDTH(RW)) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .FREEZE               (FREEZE),
      .Dispatch_Valid_IN    (Dispatch_Valid_IN),
      .Dispatch_Ready_OUT   (Dispatch_Ready_OUT),
      .ROBPointer_Alloc_OUT (ROBPointer_Alloc_OUT),
      .Valid_Instruction_IN (Valid_Instruction_IN),
      .ROBPointer_IN        (ROBPointer_IN),
      .PCA_IN               (PCA_IN),
      .writeRegister1_IN    (writeRegister1_IN),
      .RegDest_IN           (RegDest_IN),
      .aluresult_IN         (aluresult_IN),
      .address_IN           (address_IN),
      .Dest_Value1_IN       (Dest_Value1_IN),
      .MemRead1_IN          (MemRead1_IN),
      .MemWrite1_IN         (MemWrite1_IN),
      .Branch_flag_IN       (Branch_flag_IN),
      .target_PC_IN         (target_PC_IN),
      .LoadData_Valid_IN    (LoadData_Valid_IN),
      .LoadData_ROB_IN      (LoadData_ROB_IN),
      .LoadData_IN          (LoadData_IN),
      .fwd_data_1_COM       (fwd_data_1_COM),
      .fwd_reg_1_COM        (fwd_reg_1_COM),
      .fwd_data_1_COM_flag  (fwd_data_1_COM_flag),
      .LS_fwd_data_COM      (LS_fwd_data_COM),
      .LS_fwd_reg_COM       (LS_fwd_reg_COM),
      .LS_fwd_data_COM_flag (LS_fwd_data_COM_flag),
      .Store_Commit_OUT     (Store_Commit_OUT),
      .Store_Address_OUT    (Store_Address_OUT),
      .Store_Data_OUT       (Store_Data_OUT),
      .Flush_OUT            (Flush_OUT),
      .Redirect_PC_OUT      (Redirect_PC_OUT),
      .Count_OUT            (Count_OUT),
      .Empty_OUT            (Empty_OUT)
   );

   initial forever #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%08h want=%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entry status 0=free 1=pending 2=waiting-load 3=done, q holds program order.
   int          m_st  [DEPTH];
   int          m_reg [DEPTH];
   bit          m_rd  [DEPTH];
   bit          m_ld  [DEPTH];
   bit          m_sto [DEPTH];
   bit          m_tk  [DEPTH];
   logic [31:0] m_res [DEPTH];
   logic [31:0] m_addr[DEPTH];
   logic [31:0] m_sd  [DEPTH];
   logic [31:0] m_tgt [DEPTH];
   int          q[$];
   int          m_tail;
   bit          e_fwd_f, e_ls_f, e_sc, e_fl;
   int          e_fwd_r, e_ls_r;
   logic [31:0] e_fwd_d, e_ls_d, e_sa, e_sd, e_rpc;

   task automatic model_clear(input bit outs);
      for (int i = 0; i < DEPTH; i++) m_st[i] = 0;
      q.delete();
      m_tail = 0;
      if (outs) begin
         e_fwd_f = 0; e_ls_f = 0; e_sc = 0; e_fl = 0;
         e_fwd_r = 0; e_ls_r = 0;
         e_fwd_d = '0; e_ls_d = '0; e_sa = '0; e_sd = '0; e_rpc = '0;
      end
   endtask

   task automatic model_step();
      bit c, f, rdy;
      int h, p, lp;
      if (!RESET) begin
         model_clear(1'b1);
         return;
      end
      rdy = (q.size() < DEPTH) && !FREEZE;
      c   = !FREEZE && (q.size() > 0) && (m_st[q[0]] == 3);
      h   = c ? q[0] : 0;
      f   = c && m_tk[h];
      e_fwd_f = 0; e_ls_f = 0; e_sc = 0; e_fl = 0;
      if (c) begin
         if (!m_ld[h] && !m_sto[h] && m_rd[h] && m_reg[h] != 0) begin
            e_fwd_f = 1; e_fwd_d = m_res[h]; e_fwd_r = m_reg[h];
         end
         if (m_ld[h] && m_reg[h] != 0) begin
            e_ls_f = 1; e_ls_d = m_res[h]; e_ls_r = m_reg[h];
         end
         if (m_sto[h]) begin
            e_sc = 1; e_sa = m_addr[h]; e_sd = m_sd[h];
         end
         if (f) begin
            e_fl = 1; e_rpc = m_tgt[h];
         end
      end
      if (f) begin
         model_clear(1'b0);
         return;
      end
      lp = int'(LoadData_ROB_IN);
      p  = int'(ROBPointer_IN);
      if (LoadData_Valid_IN && m_st[lp] == 2) begin
         m_res[lp] = LoadData_IN;
         m_st[lp]  = 3;
      end
      if (Valid_Instruction_IN && m_st[p] == 1) begin
         m_reg[p]  = int'(writeRegister1_IN);
         m_rd[p]   = RegDest_IN;
         m_res[p]  = aluresult_IN;
         m_addr[p] = address_IN;
         m_sd[p]   = Dest_Value1_IN;
         m_ld[p]   = MemRead1_IN;
         m_sto[p]  = MemWrite1_IN;
         m_tk[p]   = Branch_flag_IN;
         m_tgt[p]  = target_PC_IN;
         m_st[p]   = MemRead1_IN ? 2 : 3;
      end
      if (c) begin
         m_st[h] = 0;
         void'(q.pop_front());
      end
      if (Dispatch_Valid_IN && rdy) begin
         m_st[m_tail] = 1;
         q.push_back(m_tail);
         m_tail = (m_tail + 1) % DEPTH;
      end
   endtask

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   // Per-cycle comparison against the model, sampled just after the edge.
   initial forever begin
      bit exp_rdy;
      @(posedge CLK);
      #1;
      if (cmp_en) begin
         exp_rdy = (q.size() < DEPTH) && !FREEZE;
         chk("cmp_ready",    32'(Dispatch_Ready_OUT),   32'(exp_rdy));
         chk("cmp_alloc",    32'(ROBPointer_Alloc_OUT), 32'(m_tail));
         chk("cmp_count",    32'(Count_OUT),            32'(q.size()));
         chk("cmp_empty",    32'(Empty_OUT),            32'(q.size() == 0));
         chk("cmp_fwd_flag", 32'(fwd_data_1_COM_flag),  32'(e_fwd_f));
         chk("cmp_fwd_data", fwd_data_1_COM,            e_fwd_d);
         chk("cmp_fwd_reg",  32'(fwd_reg_1_COM),        32'(e_fwd_r));
         chk("cmp_ls_flag",  32'(LS_fwd_data_COM_flag), 32'(e_ls_f));
         chk("cmp_ls_data",  LS_fwd_data_COM,           e_ls_d);
         chk("cmp_ls_reg",   32'(LS_fwd_reg_COM),       32'(e_ls_r));
         chk("cmp_st_commit",32'(Store_Commit_OUT),     32'(e_sc));
         chk("cmp_st_addr",  Store_Address_OUT,         e_sa);
         chk("cmp_st_data",  Store_Data_OUT,            e_sd);
         chk("cmp_flush",    32'(Flush_OUT),            32'(e_fl));
         chk("cmp_redirect", Redirect_PC_OUT,           e_rpc);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
   endtask

   task automatic dispatch(input int n);
      Dispatch_Valid_IN = 1'b1;
      repeat (n) tick();
      Dispatch_Valid_IN = 1'b0;
   endtask

   task automatic exec_op(input int ptr, input int rg, input bit rd, input logic [31:0] res,
                          input logic [31:0] addr, input logic [31:0] sd, input bit mr,
                          input bit mw, input bit br, input logic [31:0] tgt);
      Valid_Instruction_IN = 1'b1;
      ROBPointer_IN        = RW'(ptr);
      PCA_IN               = 32'h1000 + 32'(ptr * 4);
      writeRegister1_IN    = 6'(rg);
      RegDest_IN           = rd;
      aluresult_IN         = res;
      address_IN           = addr;
      Dest_Value1_IN       = sd;
      MemRead1_IN          = mr;
      MemWrite1_IN         = mw;
      Branch_flag_IN       = br;
      target_PC_IN         = tgt;
      tick();
      Valid_Instruction_IN = 1'b0;
   endtask

   task automatic load_ret(input int ptr, input logic [31:0] d);
      LoadData_Valid_IN = 1'b1;
      LoadData_ROB_IN   = RW'(ptr);
      LoadData_IN       = d;
      tick();
      LoadData_Valid_IN = 1'b0;
   endtask

   initial begin
      RESET = 1'b0; FREEZE = 1'b0; Dispatch_Valid_IN = 1'b0;
      Valid_Instruction_IN = 1'b0; ROBPointer_IN = '0; PCA_IN = '0;
      writeRegister1_IN = '0; RegDest_IN = 1'b0; aluresult_IN = '0;
      address_IN = '0; Dest_Value1_IN = '0; MemRead1_IN = 1'b0;
      MemWrite1_IN = 1'b0; Branch_flag_IN = 1'b0; target_PC_IN = '0;
      LoadData_Valid_IN = 1'b0; LoadData_ROB_IN = '0; LoadData_IN = '0;

      tick();
      cmp_en = 1'b1;
      tick();
      RESET = 1'b1;
      chk("rst_empty",    32'(Empty_OUT),            32'd1);
      chk("rst_count",    32'(Count_OUT),            32'd0);
      chk("rst_fwd_flag", 32'(fwd_data_1_COM_flag),  32'd0);
      chk("rst_flush",    32'(Flush_OUT),            32'd0);

      // Out-of-order completion, in-order commit.
      dispatch(3);
      exec_op(2, 7, 1, 32'h33, 0, 0, 0, 0, 0, 0);
      exec_op(0, 5, 1, 32'h11, 0, 0, 0, 0, 0, 0);
      exec_op(1, 6, 1, 32'h22, 0, 0, 0, 0, 0, 0);
      chk("ooo_reg0",  32'(fwd_reg_1_COM),       32'd5);
      chk("ooo_flag0", 32'(fwd_data_1_COM_flag), 32'd1);
      chk("ooo_data0", fwd_data_1_COM,           32'h11);
      tick();
      chk("ooo_reg1",  32'(fwd_reg_1_COM),       32'd6);
      chk("ooo_flag1", 32'(fwd_data_1_COM_flag), 32'd1);
      tick();
      chk("ooo_reg2",  32'(fwd_reg_1_COM),       32'd7);
      chk("ooo_data2", fwd_data_1_COM,           32'h33);
      tick();
      chk("ooo_flag_off", 32'(fwd_data_1_COM_flag), 32'd0);
      chk("ooo_hold",     fwd_data_1_COM,           32'h33);

      // Load; a return coinciding with its own execute write must be ignored.
      do_reset();
      dispatch(1);
      LoadData_Valid_IN = 1'b1; LoadData_ROB_IN = '0; LoadData_IN = 32'hBAD0BAD0;
      exec_op(0, 9, 0, 0, 32'h100, 0, 1, 0, 0, 0);
      LoadData_Valid_IN = 1'b0;
      repeat (4) tick();
      chk("ld_wait_flag",  32'(LS_fwd_data_COM_flag), 32'd0);
      chk("ld_wait_count", 32'(Count_OUT),            32'd1);
      load_ret(0, 32'hDEADBEEF);
      chk("ld_not_yet", 32'(LS_fwd_data_COM_flag), 32'd0);
      tick();
      chk("ld_flag", 32'(LS_fwd_data_COM_flag), 32'd1);
      chk("ld_reg",  32'(LS_fwd_reg_COM),       32'd9);
      chk("ld_data", LS_fwd_data_COM,           32'hDEADBEEF);
      tick();
      chk("ld_flag_off", 32'(LS_fwd_data_COM_flag), 32'd0);

      // Store commit.
      do_reset();
      dispatch(1);
      exec_op(0, 3, 0, 0, 32'h200, 32'h55, 0, 1, 0, 0);
      tick();
      chk("st_commit", 32'(Store_Commit_OUT),     32'd1);
      chk("st_addr",   Store_Address_OUT,         32'h200);
      chk("st_data",   Store_Data_OUT,            32'h55);
      chk("st_nofwd",  32'(fwd_data_1_COM_flag),  32'd0);
      chk("st_nols",   32'(LS_fwd_data_COM_flag), 32'd0);
      tick();
      chk("st_off", 32'(Store_Commit_OUT), 32'd0);

      // Taken branch flushes younger completed entries; dispatch in that cycle is lost.
      do_reset();
      dispatch(4);
      exec_op(1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400);
      exec_op(2, 2, 1, 32'h22, 0, 0, 0, 0, 0, 0);
      exec_op(3, 3, 1, 32'h33, 0, 0, 0, 0, 0, 0);
      exec_op(0, 1, 1, 32'hA1, 0, 0, 0, 0, 0, 0);
      tick();
      chk("br_pre_reg",   32'(fwd_reg_1_COM), 32'd1);
      chk("br_pre_count", 32'(Count_OUT),     32'd3);
      Dispatch_Valid_IN = 1'b1;
      tick();
      Dispatch_Valid_IN = 1'b0;
      chk("br_flush",    32'(Flush_OUT),           32'd1);
      chk("br_redirect", Redirect_PC_OUT,          32'h400);
      chk("br_count",    32'(Count_OUT),           32'd0);
      chk("br_alloc",    32'(ROBPointer_Alloc_OUT),32'd0);
      tick();
      chk("br_flush_off", 32'(Flush_OUT),           32'd0);
      chk("br_no_commit", 32'(fwd_data_1_COM_flag), 32'd0);
      exec_op(3, 3, 1, 32'h99, 0, 0, 0, 0, 0, 0);
      tick();
      chk("br_stale_flag",  32'(fwd_data_1_COM_flag), 32'd0);
      chk("br_stale_empty", 32'(Empty_OUT),           32'd1);

      // Near-full commit+dispatch with tail wrap, then full.
      do_reset();
      dispatch(63);
      chk("fill_count", 32'(Count_OUT),            32'd63);
      chk("fill_alloc", 32'(ROBPointer_Alloc_OUT), 32'd63);
      exec_op(0, 4, 1, 32'h44, 0, 0, 0, 0, 0, 0);
      Dispatch_Valid_IN = 1'b1;
      tick();
      chk("wrap_count", 32'(Count_OUT),            32'd63);
      chk("wrap_alloc", 32'(ROBPointer_Alloc_OUT), 32'd0);
      chk("wrap_reg",   32'(fwd_reg_1_COM),        32'd4);
      tick();
      chk("full_count", 32'(Count_OUT),            32'd64);
      chk("full_ready", 32'(Dispatch_Ready_OUT),   32'd0);
      tick();
      Dispatch_Valid_IN = 1'b0;
      chk("full_ign_count", 32'(Count_OUT),            32'd64);
      chk("full_ign_alloc", 32'(ROBPointer_Alloc_OUT), 32'd1);

      // Freeze blocks commit of a done head; reset mid-stream drops everything.
      FREEZE = 1'b1;
      exec_op(1, 8, 1, 32'h88, 0, 0, 0, 0, 0, 0);
      repeat (3) begin
         tick();
         chk("frz_flag",  32'(fwd_data_1_COM_flag), 32'd0);
         chk("frz_count", 32'(Count_OUT),           32'd64);
      end
      FREEZE = 1'b0;
      RESET  = 1'b0;
      tick();
      chk("mrst_flag",  32'(fwd_data_1_COM_flag), 32'd0);
      chk("mrst_empty", 32'(Empty_OUT),           32'd1);
      chk("mrst_data",  fwd_data_1_COM,           32'd0);
      chk("mrst_reg",   32'(fwd_reg_1_COM),       32'd0);
      RESET = 1'b1;
      tick();
      chk("post_empty", 32'(Empty_OUT),           32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
